// File: rtl/ex_sb_pkg.sv
// Shared types and helpers for the EX hazard scoreboard.
// Slot records carry a fixed-width rd field; RF_AW must not exceed SB_RD_W.
package ex_sb_pkg;

   localparam int SB_RD_W  = 8;
   localparam int FWD_NONE = 0;

   typedef struct packed {
      logic               valid;
      logic [SB_RD_W-1:0] rd;
      logic               wr;
      logic               is_load;
   } sb_slot_t;

   function automatic int fwd_w(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sb_src_match.sv
// Per-source RAW match against the checked tracker slots (EX..DEPTH-1).
// Reports any hit, the youngest matching slot and a load-use hit on slot 0.
module sb_src_match
   import ex_sb_pkg::*;
#(
   parameter int RF_AW = 5,
   parameter int DEPTH = 2,
   parameter int FW    = fwd_w(DEPTH)
) (
   input  logic [RF_AW-1:0]       src,
   input  logic                   used,
   input  sb_slot_t [DEPTH-1:0]   slots,
   output logic                   hit,
   output logic [FW-1:0]          idx,
   output logic                   load_use
);

   logic [DEPTH-1:0] match_s;
   logic             unused_s;

   // Per-slot pending-writer match; x0 is never pending
   always_comb begin
      match_s = '0;
      for (int k = 0; k < DEPTH; k++) begin
         match_s[k] = used & slots[k].valid & slots[k].wr &
                      (slots[k].rd != '0) & (slots[k].rd == SB_RD_W'(src));
      end
   end

   // Scan oldest to youngest so the smallest matching index wins
   always_comb begin
      idx = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         idx = match_s[k] ? FW'(k) : idx;
      end
   end

   // Load flags of older slots never matter for a load-use decision
   always_comb begin
      unused_s = 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
         unused_s = unused_s ^ slots[k].is_load;
      end
   end

   assign hit      = |match_s;
   assign load_use = match_s[0] & slots[0].is_load;

endmodule

// File: rtl/ex_hazard_scoreboard.sv
// EX-stage RAW hazard scoreboard: in-flight tracker, ID->EX handshake, stall counter.
// Define EX_FORWARDING_EN to resolve non-load hazards by forwarding instead of stalling.
module ex_hazard_scoreboard
   import ex_sb_pkg::*;
#(
   parameter int RF_AW = 5,
   parameter int DEPTH = 2,
   parameter int CW    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_id_valid,
   input  logic [RF_AW-1:0]         i_id_rs1,
   input  logic [RF_AW-1:0]         i_id_rs2,
   input  logic [1:0]               i_id_check_regs,
   input  logic [RF_AW-1:0]         i_id_rd,
   input  logic                     i_id_rd_wr,
   input  logic                     i_id_is_load,
   input  logic                     i_down_ready,
   input  logic                     i_flush,
   output logic                     o_ex_ready,
   output logic                     o_stall,
   output logic [fwd_w(DEPTH)-1:0]  o_fwd_rs1,
   output logic [fwd_w(DEPTH)-1:0]  o_fwd_rs2,
   output logic                     o_issue,
   output logic [CW-1:0]            o_stall_cycles
);

   localparam int FW = fwd_w(DEPTH);

   // The WB slot is write-through and never consulted, so only EX..DEPTH-1 are stored
   sb_slot_t [DEPTH-1:0] slots_r;
   sb_slot_t             cand_s;
   logic                 hit1_s, hit2_s, lu1_s, lu2_s;
   logic [FW-1:0]        idx1_s, idx2_s;
   logic                 hazard_s, accept_s;
   logic [CW-1:0]        cnt_r;

   sb_src_match #(.RF_AW(RF_AW), .DEPTH(DEPTH), .FW(FW)) u_match_rs1 (
      .src(i_id_rs1), .used(i_id_check_regs[0]), .slots(slots_r),
      .hit(hit1_s), .idx(idx1_s), .load_use(lu1_s)
   );

   sb_src_match #(.RF_AW(RF_AW), .DEPTH(DEPTH), .FW(FW)) u_match_rs2 (
      .src(i_id_rs2), .used(i_id_check_regs[1]), .slots(slots_r),
      .hit(hit2_s), .idx(idx2_s), .load_use(lu2_s)
   );

   assign cand_s = '{valid: 1'b1, rd: SB_RD_W'(i_id_rd), wr: i_id_rd_wr, is_load: i_id_is_load};

`ifdef EX_FORWARDING_EN
   logic [FW-1:0] fwd1_r, fwd2_r;

   assign hazard_s = lu1_s | lu2_s;

   // Forward selects: producer moves one slot as the consumer enters EX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd1_r <= FW'(FWD_NONE);
         fwd2_r <= FW'(FWD_NONE);
      end else if (i_down_ready) begin
         fwd1_r <= (accept_s & hit1_s) ? idx1_s + FW'(1) : FW'(FWD_NONE);
         fwd2_r <= (accept_s & hit2_s) ? idx2_s + FW'(1) : FW'(FWD_NONE);
      end else begin
         fwd1_r <= fwd1_r;
         fwd2_r <= fwd2_r;
      end
   end

   assign o_fwd_rs1 = fwd1_r;
   assign o_fwd_rs2 = fwd2_r;
`else
   logic unused_s;

   assign hazard_s  = hit1_s | hit2_s;
   assign unused_s  = ^{idx1_s, idx2_s, lu1_s, lu2_s};
   assign o_fwd_rs1 = FW'(FWD_NONE);
   assign o_fwd_rs2 = FW'(FWD_NONE);
`endif

   assign o_stall        = i_id_valid & hazard_s & ~i_flush;
   assign o_ex_ready     = i_down_ready & ~o_stall & ~i_flush;
   assign accept_s       = i_id_valid & o_ex_ready;
   assign o_issue        = i_down_ready & slots_r[0].valid;
   assign o_stall_cycles = cnt_r;

   // Tracker shift: advances only when downstream accepts, bubble unless a candidate enters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slots_r <= '0;
      end else if (i_down_ready) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            slots_r[k] <= slots_r[k-1];
         end
         slots_r[0] <= accept_s ? cand_s : '0;
      end else begin
         slots_r <= slots_r;
      end
   end

   // Saturating count of stall cycles that actually cost a pipeline slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (o_stall & i_down_ready & (cnt_r != {CW{1'b1}})) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: doc/ex_hazard_scoreboard.md
Name: ex_hazard_scoreboard

Overview:
- Parametrised successor to the fixed EX-stage stall controller. Tracks every in-flight instruction from EX down to WB in a DEPTH+1-slot shift pipeline.
- Detects read-after-write (RAW) hazards for the instruction waiting in ID and produces the ID→EX handshake.
- Optionally resolves hazards by forwarding rather than stalling. Honours downstream backpressure and branch flush.
- Sits between ID and the EX datapath; its outputs drive the EX operand muxes and the ID freeze.

Parameters:
- RF_AW, 5, register-file address width.
- DEPTH, 2, downstream slots after EX. Slot 0 = EX, slot 1 = MEM, …, slot DEPTH = WB.
- CW, 32, stall-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- i_id_valid  in  1  ID holds a candidate instruction
- i_id_rs1  in  RF_AW  source 1 address
- i_id_rs2  in  RF_AW  source 2 address
- i_id_check_regs  in  2  bit0 = rs1 used, bit1 = rs2 used
- i_id_rd  in  RF_AW  destination address
- i_id_rd_wr  in  1  candidate writes rd
- i_id_is_load  in  1  candidate is a load
- i_down_ready  in  1  MEM accepts; 0 freezes the whole tracker
- i_flush  in  1  taken branch/jump in EX; kill the ID candidate
- o_ex_ready  out  1  candidate accepted into EX this cycle (when i_id_valid=1)
- o_stall  out  1  hazard stall active
- o_fwd_rs1  out  $clog2(DEPTH+1)  forward source slot for EX rs1; 0 = register file
- o_fwd_rs2  out  $clog2(DEPTH+1)  as o_fwd_rs1, for rs2
- o_issue  out  1  slot 0 holds a valid instruction and advances this cycle
- o_stall_cycles  out  CW  saturating stall-cycle count

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - all slots invalid; o_fwd_rs1/o_fwd_rs2 = 0; o_stall_cycles = 0.
  - Combinational outputs follow: o_stall = 0, o_issue = 0, o_ex_ready = i_down_ready.
- Reset asserted mid-operation clears everything in the same cycle; no in-flight state survives.
- Slot contents: valid, rd, wr, is_load.
- Pending slot: valid & wr & rd != 0. x0 is never pending.
- Match: source used & source == slot.rd & slot pending. Only slots 0..DEPTH-1 are checked. Slot DEPTH (WB) is write-through in the RF, so it never causes a hazard.
- hazard: any match, with the FWD_EN rules below. Computed combinationally.
- o_stall = i_id_valid & hazard & ~i_flush.
- o_ex_ready = i_down_ready & ~o_stall & ~i_flush.
- Advance (i_down_ready=1):
  - slot k+1 <= slot k, for k = 0..DEPTH-1.
  - slot 0 <= candidate if i_id_valid & o_ex_ready, else a bubble (valid=0).
- Freeze (i_down_ready=0): all slots, fwd selects and counter hold. o_ex_ready=0.
- Flush: when i_down_ready=1, slot 0 receives a bubble and the candidate is dropped (ID must discard it). Instructions older than the candidate, including the branch, advance normally.
- Flush during freeze: no effect beyond blocking acceptance.
- o_issue = i_down_ready & slot0.valid.
- Forward selects are registered and loaded on accept. For the youngest matching slot k (smallest k), o_fwd = k+1, because the producer moves one slot as the consumer enters EX.
- On a bubble insert, o_fwd = 0.
- o_stall_cycles increments when o_stall & i_down_ready, and saturates at 2^CW-1.

Optional Feature:
- Macro: EX_FORWARDING_EN.
- Defined:
  - Only a load-use match stalls, i.e. a match on slot 0 with slot0.is_load. This is a 1-cycle stall.
  - All other matches accept immediately with forward select = k+1.
  - After a load-use stall the load sits in slot 1, so the consumer receives fwd = 2.
- Undefined:
  - Any match stalls until the producer reaches slot DEPTH.
  - o_fwd_rs1/o_fwd_rs2 are tied to 0 and their registers are not built.

Decomposition:
- Package ex_sb_pkg:
  - typedef sb_slot_t {valid, rd, wr, is_load}
  - localparam FWD_NONE = 0
  - fwd select width function
- Sub-module sb_src_match: combinational, one per source (2 instances). Inputs: source address, used bit, slot array. Outputs: hit, youngest index, load_use flag.

Test Plan:
- Reset mid-stream, slots full → all slots invalid and o_stall_cycles=0 in the same cycle; o_ex_ready = i_down_ready.
- FWD off:
  - "add x5" accepted, next "sub x6,x5,x1" → o_stall=1 for 2 cycles (DEPTH=2), accepted on cycle 3, o_stall_cycles=2.
  - "rs1=x0" after "rd=x0" writer → no stall.
- FWD on:
  - ALU "rd=x7", then consumer of x7 → no stall, o_fwd_rs1=1.
  - Consumer one instruction later → o_fwd_rs1=2.
- FWD on, "lw x9", then "add x3,x9,x9" → 1 stall cycle, then accept with o_fwd_rs1=o_fwd_rs2=2, o_stall_cycles=1.
- i_down_ready=0 for 3 cycles during a hazard → slots and counter frozen, o_ex_ready=0; the hazard resolves only after i_down_ready returns.
- i_flush with a valid candidate and i_down_ready=1 → slot 0 becomes a bubble and o_issue=0 next cycle; with i_down_ready=0 → state unchanged.
